// File: rtl/cond_eval_unit_pkg.sv
// cond_eval_unit_pkg
// Shared constants for the condition-evaluation unit:
//   - 4-bit condition codes EQ..NV as presented on in_cond lanes
//   - bit positions of N, Z, C and V inside the 4-bit {N,Z,C,V} flag word
package cond_eval_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval_unit_decode.sv
// cond_decode
// Purely combinational evaluation of one condition code against a flag word.
// Ports:
//   cond  in  4  condition code (EQ..NV)
//   flags in  4  flag word {N,Z,C,V}
//   pass  out 1  1 when the condition holds
module cond_decode
  import cond_eval_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Condition table lookup
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_eval_unit.sv
// cond_eval_unit
// Holds the NZCV flag register and a count of in-flight flag-setting
// instructions, and evaluates LANES condition codes per cycle against the
// flags as they will be after this edge (same-cycle writes are bypassed).
// Requests that depend on flags stall (in_ready=0) while a flag writer is
// still outstanding; AL/NV never depend on flags and never stall.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pend_inc                 flag-setting instruction issued
//   flag_wr_en/mask/data     flag write-back, retires one pending writer
//   in_valid, in_cond        per-lane requests (cond i in bits [4i+3:4i])
//   in_ready                 common ready (combinational)
//   out_valid, out_pass      registered per-lane results, 1-cycle latency
//   status_out               current NZCV register
//   pend_full                pending count at its maximum
module cond_eval_unit
  import cond_eval_unit_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int PEND_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pend_inc,
  input  logic               flag_wr_en,
  input  logic [3:0]         flag_wr_mask,
  input  logic [3:0]         flag_wr_data,
  input  logic [LANES-1:0]   in_valid,
  input  logic [4*LANES-1:0] in_cond,
  output logic               in_ready,
  output logic [LANES-1:0]   out_valid,
  output logic [LANES-1:0]   out_pass,
  output logic [3:0]         status_out,
  output logic               pend_full
);

  localparam logic [PEND_W-1:0] PMAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

  logic [3:0]        nzcv;
  logic [3:0]        eff;
  logic [PEND_W-1:0] cnt;
  logic [PEND_W-1:0] cnt_next;
  logic [PEND_W-1:0] cnt_eff;
  logic [LANES-1:0]  lane_pass;
  logic [LANES-1:0]  lane_hazard;

  assign status_out = nzcv;
  assign pend_full  = (cnt == PMAX);

  // Flags as they will be after this edge; lanes evaluate against these
  assign eff = flag_wr_en ? ((nzcv & ~flag_wr_mask) | (flag_wr_data & flag_wr_mask)) : nzcv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cond_decode u_decode (
      .cond  (in_cond[4*i +: 4]),
      .flags (eff),
      .pass  (lane_pass[i])
    );
    // AL and NV ignore the flags, so an outstanding writer cannot affect them
    assign lane_hazard[i] = in_valid[i]
                          && (in_cond[4*i +: 4] != COND_AL)
                          && (in_cond[4*i +: 4] != COND_NV);
  end

  // Pending count seen by this cycle's requests: a write-back now retires one
  always_comb begin
    cnt_eff = cnt;
    if (flag_wr_en && (cnt != '0)) begin
      cnt_eff = cnt - ONE;
    end else begin
      cnt_eff = cnt;
    end
  end

  assign in_ready = ~((cnt_eff != '0) && (|lane_hazard));

  // Pending counter update with saturation at both ends
  always_comb begin
    cnt_next = cnt;
    case ({pend_inc, flag_wr_en})
      2'b10: begin
        if (cnt != PMAX) begin
          cnt_next = cnt + ONE;
        end else begin
          cnt_next = cnt;
        end
      end
      2'b01: begin
        if (cnt != '0) begin
          cnt_next = cnt - ONE;
        end else begin
          cnt_next = cnt;
        end
      end
      default: cnt_next = cnt;
    endcase
  end

  // Flag register, pending counter and registered lane results
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv      <= 4'b0000;
      cnt       <= '0;
      out_valid <= '0;
      out_pass  <= '0;
    end else begin
      nzcv <= eff;
      cnt  <= cnt_next;
      if (in_ready) begin
        out_valid <= in_valid;
        out_pass  <= in_valid & lane_pass;
      end else begin
        out_valid <= '0;
        out_pass  <= '0;
      end
    end
  end

endmodule
